// File: rtl/regfile_clr_if.sv
// regfile_clr_if: write, read and clear-handshake signals for regfile_clr.
// The master modport belongs to the agent that drives the register file;
// the slave modport belongs to the register file itself.
interface regfile_clr_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 5
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, clr_req,
        input  rd_data1, rd_data2, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, clr_req,
        output rd_data1, rd_data2, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_clr.sv
// regfile_clr: DEPTH x WIDTH register file with one synchronous write port,
// two combinational read ports and a one-word-per-cycle clear sequencer.
// The top word (DEPTH-1) is hardwired to zero.
// Optional feature: define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_clr #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,      // asynchronous, active low
    regfile_clr_if.slave bus
);
    localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    // Writes are accepted only while idle and never to the zero word.
    assign wr_ok = bus.wr_en && (state == IDLE) && (bus.wr_addr != TOP);

    // Clear sequencer; busy/done are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == TOP) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage: clearing has priority, though both cannot coincide since
    // writes require IDLE and clearing requires CLEAR.
    for (genvar i = 0; i < DEPTH - 1; i++) begin : g_word
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                mem[i] <= '0;
            else if (state == CLEAR && cnt == AW'(i))
                mem[i] <= '0;
            else if (wr_ok && bus.wr_addr == AW'(i))
                mem[i] <= bus.wr_data;
        end
    end
    assign mem[DEPTH-1] = '0;

`ifdef REGFILE_BYPASS_EN
    // Forward the incoming write so it is visible in the same cycle.
    assign bus.rd_data1 = (wr_ok && bus.wr_addr == bus.rd_addr1) ? bus.wr_data
                                                                 : mem[bus.rd_addr1];
    assign bus.rd_data2 = (wr_ok && bus.wr_addr == bus.rd_addr2) ? bus.wr_data
                                                                 : mem[bus.rd_addr2];
`else
    assign bus.rd_data1 = mem[bus.rd_addr1];
    assign bus.rd_data2 = mem[bus.rd_addr2];
`endif

    assign bus.clr_busy = busy_q;
    assign bus.clr_done = done_q;
endmodule
